// File: rtl/alu_result_writeback_if.sv
// ---------------------------------------------------------------------------
// alu_result_writeback_if
// Handshake bundle that carries one ALU result into the write-back sequencer.
//
//   in_valid  producer -> sequencer   result valid this cycle
//   in_ready  sequencer -> producer   sequencer can accept a result
//   alu_op    producer -> sequencer   ALUOp that produced the result
//   lower     producer -> sequencer   ALU Lower result
//   upper     producer -> sequencer   ALU Upper result
//   dst_lo    producer -> sequencer   destination register for Lower
//   dst_hi    producer -> sequencer   destination register for Upper
//
// master = ALU side (producer), slave = write-back sequencer.
// ---------------------------------------------------------------------------
interface alu_result_writeback_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] lower;
    logic [DATA_W-1:0] upper;
    logic [ADDR_W-1:0] dst_lo;
    logic [ADDR_W-1:0] dst_hi;

    modport master (
        output in_valid, alu_op, lower, upper, dst_lo, dst_hi,
        input  in_ready
    );

    modport slave (
        input  in_valid, alu_op, lower, upper, dst_lo, dst_hi,
        output in_ready
    );
endinterface

// File: rtl/alu_result_writeback.sv
// ---------------------------------------------------------------------------
// alu_result_writeback
// Write-back sequencer on the ALU result side. Accepts one ALU result per
// handshake and turns it into writes on the register file's single write
// port. Divide and swap produce two results and take two consecutive write
// cycles (Lower to dst_lo, then Upper to dst_hi); every other defined op
// takes one write. Also keeps zero flags for the last Lower/Upper written.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset (0 = reset)
//   res       slave modport of alu_result_writeback_if (result handshake)
//   rf_we     out  register file write enable (registered)
//   rf_waddr  out  register file write address (registered)
//   rf_wdata  out  register file write data (registered)
//   zero      out  [0] last Lower written was 0, [1] last Upper written was 0
//   op_err    out  one-cycle pulse when an undefined alu_op is accepted
// ---------------------------------------------------------------------------
module alu_result_writeback #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_result_writeback_if.slave res,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic [1:0]           zero,
    output logic                 op_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t            state;
    logic              hi_pend;
    logic [DATA_W-1:0] hold_hi;
    logic [ADDR_W-1:0] hold_addr;

    logic accept;
    logic op_single;
    logic op_double;

    // A pending Upper write owns the write port on the next edge, so the
    // producer is held off for exactly that one cycle.
    assign res.in_ready = !hi_pend;
    assign accept       = res.in_valid && !hi_pend;

    // Decode the op into single-write, double-write or undefined.
    always_comb begin
        op_single = 1'b0;
        op_double = 1'b0;
        case (res.alu_op)
            4'b0000, 4'b0001, 4'b0100,
            4'b0111, 4'b1001, 4'b1011: op_single = 1'b1;
            4'b0101, 4'b1000:          op_double = 1'b1;
            default: ;
        endcase
    end

    // Sequencer: a new accept always issues the Lower write; otherwise a
    // pending Upper write is issued; otherwise the port goes idle while
    // address and data keep their last values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hi_pend   <= 1'b0;
            hold_hi   <= '0;
            hold_addr <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            zero      <= 2'b00;
            op_err    <= 1'b0;
        end else begin
            op_err <= 1'b0;
            if (accept) begin
                if (op_single || op_double) begin
                    rf_we    <= 1'b1;
                    rf_waddr <= res.dst_lo;
                    rf_wdata <= res.lower;
                    zero[0]  <= (res.lower == '0);
                    state    <= WR_LO;
                    if (op_double) begin
                        hold_hi   <= res.upper;
                        hold_addr <= res.dst_hi;
                        hi_pend   <= 1'b1;
                    end
                end else begin
                    rf_we  <= 1'b0;
                    op_err <= 1'b1;
                    state  <= IDLE;
                end
            end else if (state == WR_LO && hi_pend) begin
                rf_we    <= 1'b1;
                rf_waddr <= hold_addr;
                rf_wdata <= hold_hi;
                zero[1]  <= (hold_hi == '0);
                hi_pend  <= 1'b0;
                state    <= WR_HI;
            end else begin
                rf_we <= 1'b0;
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_writeback.sv
// ---------------------------------------------------------------------------
// tb_alu_result_writeback
// Self-checking bench for alu_result_writeback: a directed vector table,
// a hand-written reset-during-double-write sequence, and randomized traffic
// compared against a queue-based model of scheduled register writes.
// ---------------------------------------------------------------------------
module tb_alu_result_writeback;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int RAND_CYCLES = 400;

    logic              clk;
    logic              rst;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [1:0]        zero;
    logic              op_err;

    int errors = 0;
    int checks = 0;

    alu_result_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    alu_result_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .res      (bus.slave),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .zero     (zero),
        .op_err   (op_err)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [15:0] lo;
        logic [15:0] up;
        logic [3:0]  dl;
        logic [3:0]  dh;
        logic        expWe;
        logic [3:0]  expAddr;
        logic [15:0] expData;
        logic [1:0]  expZero;
        logic        expReady;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        logic        isUpper;
    } wr_t;

    // Reference model state: writes scheduled for future edges plus the
    // expected visible outputs.
    wr_t         sched[$];
    logic        mWe;
    logic [3:0]  mAddr;
    logic [15:0] mData;
    logic [1:0]  mZero;
    logic        mReady;
    logic        mErr;

    // Compare one value and count the result.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs (called just after a negedge), let the
    // rising edge happen, and return at the next negedge for sampling.
    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [15:0] lo,
                                 input logic [15:0] up, input logic [3:0] dl, input logic [3:0] dh);
        bus.in_valid = v;
        bus.alu_op   = op;
        bus.lower    = lo;
        bus.upper    = up;
        bus.dst_lo   = dl;
        bus.dst_hi   = dh;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int opClass(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0100, 4'b0111, 4'b1001, 4'b1011: return 1;
            4'b0101, 4'b1000: return 2;
            default: return 0;
        endcase
    endfunction

    task automatic modelReset();
        sched.delete();
        mWe = 0; mAddr = 0; mData = 0; mZero = 2'b00; mReady = 1; mErr = 0;
    endtask

    task automatic modelIssue(input wr_t w);
        mWe   = 1'b1;
        mAddr = w.addr;
        mData = w.data;
        if (w.isUpper) mZero[1] = (w.data == 0);
        else           mZero[0] = (w.data == 0);
    endtask

    // Advance the model by one clock edge with the current inputs. A
    // scheduled write always takes the port; a result is only taken when
    // nothing is scheduled.
    task automatic modelStep(input logic v, input logic [3:0] op, input logic [15:0] lo,
                             input logic [15:0] up, input logic [3:0] dl, input logic [3:0] dh,
                             output logic accepted);
        wr_t w;
        int  cls;
        mErr = 0;
        accepted = v && (sched.size() == 0);
        if (sched.size() > 0) begin
            w = sched.pop_front();
            modelIssue(w);
        end else if (v) begin
            cls = opClass(op);
            if (cls == 0) begin
                mWe  = 0;
                mErr = 1;
            end else begin
                w.addr = dl; w.data = lo; w.isUpper = 0;
                modelIssue(w);
                if (cls == 2) begin
                    w.addr = dh; w.data = up; w.isUpper = 1;
                    sched.push_back(w);
                end
            end
        end else begin
            mWe = 0;
        end
        mReady = (sched.size() == 0);
    endtask

    task automatic checkAll(input string tag, input logic eWe, input logic [3:0] eAddr,
                            input logic [15:0] eData, input logic [1:0] eZero,
                            input logic eReady, input logic eErr);
        checkOutput({tag, ".rf_we"},    32'(rf_we),        32'(eWe));
        checkOutput({tag, ".rf_waddr"}, 32'(rf_waddr),     32'(eAddr));
        checkOutput({tag, ".rf_wdata"}, 32'(rf_wdata),     32'(eData));
        checkOutput({tag, ".zero"},     32'(zero),         32'(eZero));
        checkOutput({tag, ".in_ready"}, 32'(bus.in_ready), 32'(eReady));
        checkOutput({tag, ".op_err"},   32'(op_err),       32'(eErr));
    endtask

    vec_t vecs[12];

    initial begin
        logic        acc;
        logic        pv;
        logic [3:0]  pop;
        logic [15:0] plo, pup;
        logic [3:0]  pdl, pdh;
        logic [3:0]  defOps[8];

        defOps = '{4'b0000, 4'b0001, 4'b0100, 4'b0111, 4'b1001, 4'b1011, 4'b0101, 4'b1000};

        //           v  op       lower     upper     dl  dh  we a   data      zero   rdy err
        vecs[0]  = '{1, 4'b0000, 16'h0005, 16'h1234, 3,  0,  1, 3,  16'h0005, 2'b00, 1,  0};
        vecs[1]  = '{0, 4'b0000, 16'h0000, 16'h0000, 0,  0,  0, 3,  16'h0005, 2'b00, 1,  0};
        vecs[2]  = '{1, 4'b0101, 16'h0004, 16'h0000, 1,  2,  1, 1,  16'h0004, 2'b00, 0,  0};
        vecs[3]  = '{1, 4'b0000, 16'h0009, 16'h0000, 9,  9,  1, 2,  16'h0000, 2'b10, 1,  0};
        vecs[4]  = '{1, 4'b1011, 16'h0000, 16'h0000, 5,  0,  1, 5,  16'h0000, 2'b11, 1,  0};
        vecs[5]  = '{1, 4'b1001, 16'h0001, 16'h0000, 6,  0,  1, 6,  16'h0001, 2'b10, 1,  0};
        vecs[6]  = '{1, 4'b0111, 16'h0002, 16'h0000, 8,  0,  1, 8,  16'h0002, 2'b10, 1,  0};
        vecs[7]  = '{1, 4'b1000, 16'hAAAA, 16'h5555, 7,  7,  1, 7,  16'hAAAA, 2'b10, 0,  0};
        vecs[8]  = '{0, 4'b0000, 16'h0000, 16'h0000, 0,  0,  1, 7,  16'h5555, 2'b00, 1,  0};
        vecs[9]  = '{1, 4'b1111, 16'h0000, 16'h0000, 4,  4,  0, 7,  16'h5555, 2'b00, 1,  1};
        vecs[10] = '{0, 4'b0000, 16'h0000, 16'h0000, 0,  0,  0, 7,  16'h5555, 2'b00, 1,  0};
        vecs[11] = '{1, 4'b0001, 16'hFFFF, 16'h0000, 15, 0,  1, 15, 16'hFFFF, 2'b00, 1,  0};

        // Reset state.
        rst = 1'b0;
        bus.in_valid = 0; bus.alu_op = 0; bus.lower = 0; bus.upper = 0;
        bus.dst_lo = 0; bus.dst_hi = 0;
        repeat (2) @(negedge clk);
        checkAll("reset", 0, 0, 16'h0000, 2'b00, 1, 0);
        rst = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].op, vecs[i].lo, vecs[i].up, vecs[i].dl, vecs[i].dh);
            checkAll($sformatf("vec%0d", i), vecs[i].expWe, vecs[i].expAddr, vecs[i].expData,
                     vecs[i].expZero, vecs[i].expReady, vecs[i].expErr);
        end

        // Reset asserted mid-cycle between the Lower and Upper writes of a div.
        applyStimulus(0, 4'b0000, 0, 0, 0, 0);
        applyStimulus(1, 4'b0101, 16'h0010, 16'h0003, 4'd10, 4'd11);
        checkAll("rstdiv.lo", 1, 10, 16'h0010, 2'b00, 0, 0);
        bus.in_valid = 0;
        #2 rst = 1'b0;
        #1;
        checkOutput("rstdiv.we_async",    32'(rf_we),        32'd0);
        checkOutput("rstdiv.ready_async", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 4'b0000, 0, 0, 0, 0);
            checkAll($sformatf("rstdiv.after%0d", i), 0, 0, 16'h0000, 2'b00, 1, 0);
        end

        // Randomized traffic against the write-schedule model; the producer
        // holds its result until it is accepted.
        modelReset();
        pv = 0; pop = 0; plo = 0; pup = 0; pdl = 0; pdh = 0;
        for (int c = 0; c < RAND_CYCLES; c++) begin
            if (!pv) begin
                pv = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 9) == 0) pop = 4'($urandom);
                else pop = defOps[$urandom_range(0, 7)];
                plo = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
                pup = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
                pdl = 4'($urandom);
                pdh = ($urandom_range(0, 4) == 0) ? pdl : 4'($urandom);
            end
            modelStep(pv, pop, plo, pup, pdl, pdh, acc);
            applyStimulus(pv, pop, plo, pup, pdl, pdh);
            checkAll($sformatf("rand%0d", c), mWe, mAddr, mData, mZero, mReady, mErr);
            if (acc) pv = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
